// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon word packer.
//   packer_state_e : packer FSM states
//   ASCON_PAD_BYTE : padding byte placed after the last message byte
//   ASCON_RATE_W   : rate block width (64)
//   ASCON_WORD_W   : bus word width (32)
//   blk_t          : one rate block
package ascon_pkg;

   typedef enum logic [1:0] {
      S_HI,
      S_LO,
      S_OUT,
      S_PAD
   } packer_state_e;

   localparam logic [7:0]  ASCON_PAD_BYTE = 8'h80;
   localparam int unsigned ASCON_RATE_W   = 64;
   localparam int unsigned ASCON_WORD_W   = 32;

   typedef logic [ASCON_RATE_W-1:0] blk_t;

endpackage

// File: rtl/ascon_pad_gen.sv
// Combinational padder for one 32-bit half of a rate block.
// Ports:
//   word   in  32  message word, byte 0 in [31:24]
//   cnt    in  3   valid bytes (0..4)
//   padded out 32  valid bytes kept, PAD_BYTE at byte cnt, zeros after
//   ovf    out 1   cnt==4: word full, the pad byte belongs to the next half
module ascon_pad_gen
   import ascon_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE = ASCON_PAD_BYTE
) (
   input  logic [ASCON_WORD_W-1:0] word,
   input  logic [2:0]              cnt,
   output logic [ASCON_WORD_W-1:0] padded,
   output logic                    ovf
);

   always_comb begin
      padded = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i < 32'(cnt))
            padded[31-8*i -: 8] = word[31-8*i -: 8];
         else if (i == 32'(cnt))
            padded[31-8*i -: 8] = PAD_BYTE;
      end
      ovf = (cnt == 3'd4);
   end

endmodule

// File: rtl/ascon_word_packer.sv
// Packs 32-bit message words into 64-bit Ascon rate blocks with padding and
// pushes them into the downstream FIFO.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush_i       synchronous clear, aborts the message in progress
//   in_valid_i / in_ready_o / in_data_i / in_last_i / in_bytes_i
//                 word handshake; in_bytes_i = valid bytes in a last word
//   push_o / data_o / last_o / full_i
//                 FIFO side; last_o marks the padded final block
//   blk_cnt_o     (ASCON_PACKER_CNT_EN only) saturating count of pushes
// Optional feature macro: ASCON_PACKER_CNT_EN
module ascon_word_packer
   import ascon_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned BLK_WIDTH = 64,
   parameter logic [7:0]  PAD_BYTE  = ASCON_PAD_BYTE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [IN_WIDTH-1:0]  in_data_i,
   input  logic                 in_last_i,
   input  logic [2:0]           in_bytes_i,
   output logic                 push_o,
   output logic [BLK_WIDTH-1:0] data_o,
   output logic                 last_o,
   input  logic                 full_i
`ifdef ASCON_PACKER_CNT_EN
   ,
   output logic [15:0]          blk_cnt_o
`endif
);

   packer_state_e state_q, state_d;
   blk_t          blk_q, blk_d;
   logic          last_q, last_d;
   logic          pend_q, pend_d;

   logic          accept;
   logic [2:0]    bytes_c;
   logic [2:0]    cnt;
   logic [31:0]   padded;
   logic          ovf;

   // Out-of-range byte counts are clamped to a full word.
   assign bytes_c = (in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
   // Non-last words are always treated as full, whatever in_bytes_i says.
   assign cnt     = in_last_i ? bytes_c : 3'd4;

   ascon_pad_gen #(.PAD_BYTE(PAD_BYTE)) u_pad (
      .word   (in_data_i),
      .cnt    (cnt),
      .padded (padded),
      .ovf    (ovf)
   );

   assign in_ready_o = (state_q == S_HI) || (state_q == S_LO);
   assign accept     = in_valid_i && in_ready_o && !flush_i;
   assign push_o     = ((state_q == S_OUT) || (state_q == S_PAD)) && !full_i && !flush_i;
   assign data_o     = (state_q == S_PAD) ? {PAD_BYTE, {(BLK_WIDTH-8){1'b0}}} : blk_q;
   assign last_o     = (state_q == S_PAD) ? 1'b1 : last_q;

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      last_d  = last_q;
      pend_d  = pend_q;
      unique case (state_q)
         S_HI: if (accept) begin
            blk_d[63:32] = padded;
            // A full last word pushes the pad byte into the low half.
            blk_d[31:0]  = (in_last_i && ovf) ? {PAD_BYTE, 24'd0} : 32'd0;
            last_d       = in_last_i;
            state_d      = in_last_i ? S_OUT : S_LO;
         end
         S_LO: if (accept) begin
            blk_d[31:0] = padded;
            // Message ending on a block boundary needs a separate pad block.
            last_d      = in_last_i && !ovf;
            pend_d      = in_last_i && ovf;
            state_d     = S_OUT;
         end
         S_OUT: if (push_o) begin
            state_d = pend_q ? S_PAD : S_HI;
         end
         S_PAD: if (push_o) begin
            state_d = S_HI;
            pend_d  = 1'b0;
         end
         default: state_d = S_HI;
      endcase
      if (flush_i) begin
         state_d = S_HI;
         blk_d   = '0;
         last_d  = 1'b0;
         pend_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HI;
         blk_q   <= '0;
         last_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
      end
   end

`ifdef ASCON_PACKER_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         blk_cnt_o <= '0;
      else if (flush_i)
         blk_cnt_o <= '0;
      else if (push_o && (blk_cnt_o != 16'hFFFF))
         blk_cnt_o <= blk_cnt_o + 16'd1;
   end
`endif

   a_bytes_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid_i && in_ready_o) |-> (in_bytes_i <= 3'd4));

endmodule

// File: tb/tb_ascon_word_packer.sv
module tb_ascon_word_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] in_data_i = '0;
   logic        in_last_i = 1'b0;
   logic [2:0]  in_bytes_i = 3'd4;
   logic        push_o;
   logic [63:0] data_o;
   logic        last_o;
   logic        full_i = 1'b0;
`ifdef ASCON_PACKER_CNT_EN
   logic [15:0] blk_cnt_o;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   ascon_word_packer #(.IN_WIDTH(32), .BLK_WIDTH(64), .PAD_BYTE(8'h80)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .in_last_i  (in_last_i),
      .in_bytes_i (in_bytes_i),
      .push_o     (push_o),
      .data_o     (data_o),
      .last_o     (last_o),
      .full_i     (full_i)
`ifdef ASCON_PACKER_CNT_EN
      ,
      .blk_cnt_o  (blk_cnt_o)
`endif
   );

   typedef struct {
      logic [31:0] d;
      logic        l;
      logic [2:0]  b;
      int unsigned np;
      logic [63:0] b0;
      logic        l0;
      logic [63:0] b1;
      logic        l1;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
      int unsigned n = 0;
      while (!in_ready_o && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready_o) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
      end
      in_valid_i = 1'b1;
      in_data_i  = d;
      in_last_i  = l;
      in_bytes_i = b;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      in_bytes_i = 3'd4;
   endtask

   // Block must be presented immediately; returns at posedge+1 after the push.
   task automatic expect_push(input string name, input logic [63:0] blk, input logic lst);
      @(negedge clk);
      chk({name, "_push"}, 64'(push_o), 64'd1);
      chk({name, "_data"}, data_o, blk);
      chk({name, "_last"}, 64'(last_o), 64'(lst));
      chk({name, "_ready"}, 64'(in_ready_o), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int unsigned exp_cnt = 0;
      logic [63:0] held;

      tbl[0]  = '{32'h0011_2233, 1'b0, 3'd4, 0, 64'h0, 1'b0, 64'h0, 1'b0};
      tbl[1]  = '{32'h4455_6677, 1'b0, 3'd4, 1, 64'h0011_2233_4455_6677, 1'b0, 64'h0, 1'b0};
      tbl[2]  = '{32'h0000_0000, 1'b1, 3'd0, 1, 64'h8000_0000_0000_0000, 1'b1, 64'h0, 1'b0};
      tbl[3]  = '{32'hAABB_CCDD, 1'b1, 3'd2, 1, 64'hAABB_8000_0000_0000, 1'b1, 64'h0, 1'b0};
      tbl[4]  = '{32'h0102_0304, 1'b0, 3'd4, 0, 64'h0, 1'b0, 64'h0, 1'b0};
      tbl[5]  = '{32'h0506_0708, 1'b1, 3'd4, 2, 64'h0102_0304_0506_0708, 1'b0,
                  64'h8000_0000_0000_0000, 1'b1};
      tbl[6]  = '{32'h1111_1111, 1'b1, 3'd4, 1, 64'h1111_1111_8000_0000, 1'b1, 64'h0, 1'b0};
      tbl[7]  = '{32'hDEAD_BEEF, 1'b1, 3'd1, 1, 64'hDE80_0000_0000_0000, 1'b1, 64'h0, 1'b0};
      tbl[8]  = '{32'hCAFE_F00D, 1'b1, 3'd3, 1, 64'hCAFE_F080_0000_0000, 1'b1, 64'h0, 1'b0};
      tbl[9]  = '{32'h1234_5678, 1'b0, 3'd4, 0, 64'h0, 1'b0, 64'h0, 1'b0};
      tbl[10] = '{32'h9ABC_DEF0, 1'b1, 3'd1, 1, 64'h1234_5678_9A80_0000, 1'b1, 64'h0, 1'b0};
      tbl[11] = '{32'h1122_3344, 1'b0, 3'd4, 0, 64'h0, 1'b0, 64'h0, 1'b0};
      tbl[12] = '{32'h5566_7788, 1'b1, 3'd3, 1, 64'h1122_3344_5566_7780, 1'b1, 64'h0, 1'b0};

      // Reset state
      #12;
      chk("rst_ready", 64'(in_ready_o), 64'd1);
      chk("rst_push", 64'(push_o), 64'd0);
      chk("rst_data", data_o, 64'd0);
      chk("rst_last", 64'(last_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven messages
      foreach (tbl[i]) begin
         send_word(tbl[i].d, tbl[i].l, tbl[i].b);
         if (tbl[i].np == 0) begin
            @(negedge clk);
            chk($sformatf("v%0d_nopush", i), 64'(push_o), 64'd0);
            chk($sformatf("v%0d_ready", i), 64'(in_ready_o), 64'd1);
            @(posedge clk); #1;
         end else begin
            expect_push($sformatf("v%0d_b0", i), tbl[i].b0, tbl[i].l0);
            if (tbl[i].np == 2)
               expect_push($sformatf("v%0d_b1", i), tbl[i].b1, tbl[i].l1);
            @(negedge clk);
            chk($sformatf("v%0d_idle_ready", i), 64'(in_ready_o), 64'd1);
            chk($sformatf("v%0d_idle_push", i), 64'(push_o), 64'd0);
            @(posedge clk); #1;
         end
         exp_cnt += tbl[i].np;
      end
`ifdef ASCON_PACKER_CNT_EN
      chk("cnt_after_table", 64'(blk_cnt_o), 64'(exp_cnt));
`endif

      // Backpressure: full_i high for 5 cycles with a block pending
      full_i = 1'b1;
      send_word(32'h1111_1111, 1'b1, 3'd4);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_push", k), 64'(push_o), 64'd0);
         chk($sformatf("bp%0d_ready", k), 64'(in_ready_o), 64'd0);
         chk($sformatf("bp%0d_data", k), data_o, 64'h1111_1111_8000_0000);
         @(posedge clk); #1;
      end
      full_i = 1'b0;
      expect_push("bp_release", 64'h1111_1111_8000_0000, 1'b1);
      @(negedge clk);
      chk("bp_after_ready", 64'(in_ready_o), 64'd1);
      @(posedge clk); #1;

      // Flush in S_LO drops the partial block and the word offered with it
      send_word(32'h1234_5678, 1'b0, 3'd4);
      flush_i    = 1'b1;
      in_valid_i = 1'b1;
      in_data_i  = 32'hFFFF_FFFF;
      in_last_i  = 1'b1;
      in_bytes_i = 3'd4;
      @(negedge clk);
      chk("flush_push", 64'(push_o), 64'd0);
      @(posedge clk); #1;
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      chk("flush_ready", 64'(in_ready_o), 64'd1);
      chk("flush_data", data_o, 64'd0);
      send_word(32'h1111_1111, 1'b1, 3'd4);
      expect_push("post_flush", 64'h1111_1111_8000_0000, 1'b1);
`ifdef ASCON_PACKER_CNT_EN
      chk("cnt_after_flush", 64'(blk_cnt_o), 64'd1);
`endif

      // Asynchronous reset while a block is being offered
      send_word(32'hAABB_CCDD, 1'b1, 3'd2);
      @(negedge clk);
      held = data_o;
      chk("arst_pre_push", 64'(push_o), 64'd1);
      chk("arst_pre_data", held, 64'hAABB_8000_0000_0000);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_push", 64'(push_o), 64'd0);
      chk("arst_ready", 64'(in_ready_o), 64'd1);
      chk("arst_data", data_o, 64'd0);
      chk("arst_last", 64'(last_o), 64'd0);
`ifdef ASCON_PACKER_CNT_EN
      chk("arst_cnt", 64'(blk_cnt_o), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_word(32'hCAFE_F00D, 1'b1, 3'd3);
      expect_push("post_rst", 64'hCAFE_F080_0000_0000, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/ascon_word_packer.md
Name: ascon_word_packer

Overview:
- Upstream feeder for the 64-bit Ascon input FIFO.
- Accepts 32-bit message words from the register/bus side and packs pairs into 64-bit rate blocks. The first word of a block goes to bits [63:32].
- Applies Ascon padding on the final word: a 0x80 byte after the last data byte, zeros after that, and an extra padding block when the message ends on a block boundary.
- Pushes each completed block into the FIFO, honouring its full flag.

Parameters:
- IN_WIDTH, 32, input word width; fixed at 32, other values unsupported.
- BLK_WIDTH, 64, output block width; must equal 2*IN_WIDTH.
- PAD_BYTE, 8'h80, padding byte inserted after the last data byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear; abort the message in progress
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  packer can accept a word
- in_data_i  in  32  message word, byte 0 in [31:24]
- in_last_i  in  1  word is the final word of the message
- in_bytes_i  in  3  valid bytes in a last word (0..4); must be 4 when in_last_i=0
- push_o  out  1  FIFO push strobe
- data_o  out  64  block to FIFO
- last_o  out  1  block carries the padding (final block of the message)
- full_i  in  1  FIFO full

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=S_HI, block register=0, in_ready_o=1, push_o=0, data_o=0, last_o=0.
- Handshake: a word transfers on in_valid_i && in_ready_o.
  - in_ready_o=1 only in S_HI or S_LO.
  - push_o = (state is S_OUT or S_PAD) && !full_i. A push completes in that cycle.
- States:
  - S_HI: accept a word into [63:32].
    - Non-last word -> S_LO.
    - Last word -> pad at byte offset in_bytes_i -> S_OUT with last=1.
  - S_LO: accept a word into [31:0].
    - Non-last word -> S_OUT with last=0.
    - Last word with in_bytes_i<4 -> pad at offset 4+in_bytes_i -> S_OUT with last=1.
    - Last word with in_bytes_i=4 -> S_OUT with last=0 and pad_pending=1.
  - S_OUT: hold data_o/last_o stable until a push completes.
    - pad_pending=1 -> S_PAD.
    - Otherwise -> S_HI.
  - S_PAD: data_o=64'h8000_0000_0000_0000, last_o=1. When the push completes -> S_HI and pad_pending clears.
- Padding: unused data bytes are forced to 0 regardless of in_data_i. Pad byte position p (0..7, byte 0 = [63:56]) receives PAD_BYTE and all later bytes are 0.
  - Last word in S_HI with in_bytes_i=4: p=4 (pad lands in the low half), block emitted, last=1.
  - Last word in S_HI with in_bytes_i=0 (empty message): block = 64'h8000_0000_0000_0000, last=1.
- Latency: the block is on data_o with push_o high the cycle after the accepting edge, provided full_i=0.
- Backpressure: full_i=1 holds S_OUT/S_PAD indefinitely; data_o and last_o stay stable; input is stalled.
- in_bytes_i>4 is illegal (assertion). Behaviour is undefined; the implementation clamps the value to 4.
- flush_i has the highest priority.
  - Next state S_HI, block register cleared, pad_pending cleared.
  - push_o is forced 0 in the flush cycle.
  - Any input word presented in that cycle is dropped.
- Reset mid-message: immediate return to reset values; a partial block is lost.
- Simultaneous push and accept cannot occur, because ready is low while a block is pending. Throughput is 2 words per 3 cycles.

Optional Feature:
- Macro: ASCON_PACKER_CNT_EN.
- When defined:
  - Adds port blk_cnt_o (out, 16): the number of blocks pushed since reset or flush.
  - The count increments on every completed push and saturates at 16'hFFFF.
  - flush_i or reset clears it.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- ascon_pkg holds:
  - packer_state_e {S_HI, S_LO, S_OUT, S_PAD}
  - ASCON_PAD_BYTE
  - ASCON_RATE_W=64
  - ASCON_WORD_W=32
  - blk_t typedef (logic [63:0])
- Register macros come from imt_registers.svh (FF/FFARNC style).
- One natural sub-module: ascon_pad_gen.
  - Purely combinational.
  - Inputs: 32-bit word and byte count.
  - Output: the masked, padded 32-bit word plus an overflow flag (count=4).
  - Used for both halves.

Test Plan:
- Two non-last words 32'h0011_2233 then 32'h4455_6677, then a last word with bytes=0 and full_i=0:
  - First block: data_o=64'h0011_2233_4455_6677, last_o=0, one push cycle after the second accept.
  - Second block: 64'h8000_0000_0000_0000, last_o=1.
- Single last word 32'hAABB_CCDD with bytes=2 -> one push of 64'hAABB_8000_0000_0000, last_o=1.
- Words 32'h0102_0304 (non-last) then 32'h0506_0708 (last, bytes=4):
  - Push 64'h0102_0304_0506_0708 with last=0.
  - Then push 64'h8000_0000_0000_0000 with last=1.
  - in_ready_o is low until both pushes complete.
- full_i held high 5 cycles with a block pending -> push_o=0, data_o stable, in_ready_o=0. Push occurs in the cycle full_i drops.
- flush_i asserted in S_LO after one word -> no push. The next message 32'h1111_1111 (last, bytes=4) yields 64'h1111_1111_8000_0000, last=1.
- Reset asserted asynchronously mid-S_OUT -> push_o and in_ready_o go to their reset values without waiting for a clock edge.
